// File: rtl/hsv_pkg.sv
// hsv_pkg: shared state encoding, widths and the packed RGB triple for the HSV colour sequencer.
package hsv_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, DIV, CHROMA, XCALC, MIX} hsv_state_t;
  localparam int SECTOR_DEG = 60;
  localparam int HUE_W = 9;
  localparam int DUTY_W = 8;
  typedef struct packed {
    logic [DUTY_W-1:0] r;
    logic [DUTY_W-1:0] g;
    logic [DUTY_W-1:0] b;
  } rgb_t;
endpackage

// File: rtl/hsv_to_rgb_core.sv
// hsv_to_rgb_core: iterative HSV to RGB converter; sector found by repeated subtraction, one result per start.
module hsv_to_rgb_core import hsv_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [HUE_W-1:0]  hue,
  input  logic [DUTY_W-1:0] sat,
  input  logic [DUTY_W-1:0] val,
  output logic              ready,
  output logic              done,
  output logic [DUTY_W-1:0] r,
  output logic [DUTY_W-1:0] g,
  output logic [DUTY_W-1:0] b
);
  hsv_state_t state, state_nx;
  logic [HUE_W-1:0] rem;
  logic [2:0] sector;
  logic [DUTY_W-1:0] s, v, c, m, ramp, x;
  logic [15:0] c_prod, x_prod;
  logic above;
  assign above = rem >= HUE_W'(SECTOR_DEG);
  assign c_prod = {8'd0, v} * ({8'd0, s} + 16'd1);
  // odd sectors ramp down, even sectors ramp up
  assign x_prod = {8'd0, c} * (sector[0] ? 16'd256 - {8'd0, ramp} : {8'd0, ramp} + 16'd1);
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE)   ? (start ? LOAD : IDLE) :
               (state == LOAD)   ? DIV :
               (state == DIV)    ? (above ? DIV : CHROMA) :
               (state == CHROMA) ? XCALC :
               (state == XCALC)  ? MIX : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rem    <= '0;
      sector <= '0;
      s      <= '0;
      v      <= '0;
      c      <= '0;
      m      <= '0;
      ramp   <= '0;
      x      <= '0;
    end else begin
      state <= state_nx;
      if (state == LOAD) begin
        rem    <= hue;
        sector <= '0;
        s      <= sat;
        v      <= val;
      end
      if (state == DIV && above) begin
        rem    <= rem - HUE_W'(SECTOR_DEG);
        sector <= sector + 3'd1;
      end
      if (state == CHROMA) begin
        c    <= 8'(c_prod >> 8);
        m    <= v - 8'(c_prod >> 8);
        ramp <= 8'(({7'd0, rem} * 16'd17) >> 2);
      end
      if (state == XCALC) x <= 8'(x_prod >> 8);
    end
  end
  assign ready = state == IDLE;
  assign done  = state == MIX;
  assign r = m + ((sector == 3'd0 || sector == 3'd5) ? c : (sector == 3'd1 || sector == 3'd4) ? x : 8'd0);
  assign g = m + ((sector == 3'd1 || sector == 3'd2) ? c : (sector == 3'd0 || sector == 3'd3) ? x : 8'd0);
  assign b = m + ((sector == 3'd3 || sector == 3'd4) ? c : (sector == 3'd2 || sector == 3'd5) ? x : 8'd0);
endmodule

// File: rtl/hsv_color_sequencer.sv
// hsv_color_sequencer: hue sweep, HSV conversion and frame-aligned commit of RGB duties to the PWM stage.
module hsv_color_sequencer import hsv_pkg::*; #(
  parameter int CLK_FREQ  = 12000000,
  parameter int SWEEP_MS  = 1000,
  parameter int HUE_STEPS = 360,
  parameter int PWM_SYNC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DUTY_W-1:0] sat,
  input  logic [DUTY_W-1:0] val,
  input  logic              frame_start,
  output logic [HUE_W-1:0]  hue,
  output logic [DUTY_W-1:0] duty_r,
  output logic [DUTY_W-1:0] duty_g,
  output logic [DUTY_W-1:0] duty_b,
  output logic              duty_valid
);
  localparam int TICK_DIV = int'(64'(CLK_FREQ) * 64'(SWEEP_MS) / 64'd1000 / 64'(HUE_STEPS));
  localparam int TW = $clog2(TICK_DIV);
  if (TICK_DIV < 16) begin : g_tick_chk
    $error("TICK_DIV must be at least 16");
  end
  logic [TW-1:0] tick;
  logic tick_end, step, start_pending, staged_valid, commit, ready, done;
  rgb_t core, staged;
  assign tick_end = tick == TW'(TICK_DIV - 1);
  assign step     = enable && tick_end;
  // a result staged in the same cycle as a frame boundary waits for the next frame
  assign commit   = (PWM_SYNC != 0) ? (frame_start && staged_valid) : done;
  hsv_to_rgb_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_pending),
    .hue   (hue),
    .sat   (sat),
    .val   (val),
    .ready (ready),
    .done  (done),
    .r     (core.r),
    .g     (core.g),
    .b     (core.b)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick          <= '0;
      hue           <= '0;
      start_pending <= 1'b1;
      staged        <= '0;
      staged_valid  <= 1'b0;
      duty_r        <= '0;
      duty_g        <= '0;
      duty_b        <= '0;
      duty_valid    <= 1'b0;
    end else begin
      if (enable) tick <= tick_end ? '0 : tick + TW'(1);
      if (step) hue <= (hue == HUE_W'(HUE_STEPS - 1)) ? '0 : hue + HUE_W'(1);
      start_pending <= step || (start_pending && !ready);
      if (done) staged <= core;
      staged_valid <= done || (staged_valid && !commit);
      duty_valid   <= commit;
      if (commit) {duty_r, duty_g, duty_b} <= (PWM_SYNC != 0) ? staged : core;
    end
  end
endmodule

// File: tb/tb_hsv_color_sequencer.sv
// tb_hsv_color_sequencer: directed hue/sat/val vectors, expected duties queued and checked on each duty_valid.
module tb_hsv_color_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, frame_start = 1'b0;
  logic [7:0] sat = 8'd255, val = 8'd255;
  logic [8:0] hue;
  logic [7:0] duty_r, duty_g, duty_b;
  logic duty_valid;
  int errors = 0, checks = 0, n_valid = 0, cyc = 0;
  bit fs_auto = 1'b0;
  logic [23:0] exp_q[$];
  logic [23:0] last = 24'h0;

  hsv_color_sequencer #(.CLK_FREQ(36000), .SWEEP_MS(1000), .HUE_STEPS(360), .PWM_SYNC(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sat(sat), .val(val), .frame_start(frame_start),
    .hue(hue), .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b), .duty_valid(duty_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (duty_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected duty_valid: got rgb 0x%06h expected no commit at %0t", {duty_r, duty_g, duty_b}, $time);
      end else chk("committed rgb", 32'({duty_r, duty_g, duty_b}), 32'(exp_q.pop_front()));
    end
  end

  task automatic step();
    @(negedge clk);
    cyc++;
    if (fs_auto) frame_start = (cyc % 256) == 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic goto_hue(input int target);
    enable = 1'b1;
    for (int i = 0; i < 40000; i++) begin
      step();
      if (32'(hue) == target) break;
    end
    enable = 1'b0;
    chk("reach hue", 32'(hue), 32'(target));
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic commit(input logic [23:0] e);
    chk("duty held until frame", 32'({duty_r, duty_g, duty_b}), 32'(last));
    exp_q.push_back(e);
    run(20);
    pulse_fs();
    run(3);
    last = e;
  endtask

  initial begin
    run(3);
    chk("reset hue", 32'(hue), 32'd0);
    chk("reset duty", 32'({duty_r, duty_g, duty_b}), 32'd0);
    chk("reset duty_valid", 32'(duty_valid), 32'd0);
    rst_n = 1'b1;
    exp_q.push_back(24'hff0000);
    fs_auto = 1'b1;
    run(600);
    fs_auto = 1'b0;
    frame_start = 1'b0;
    chk("single duty_valid after reset", 32'(n_valid), 32'd1);
    last = 24'hff0000;
    goto_hue(30);  commit(24'hff7f00);
    goto_hue(60);  commit(24'hffff00);
    goto_hue(90);  commit(24'h80ff00);
    goto_hue(120); commit(24'h00ff00);
    goto_hue(240); commit(24'h0000ff);
    goto_hue(299);
    goto_hue(300);
    chk("duty held across conversions", 32'({duty_r, duty_g, duty_b}), 32'h0000ff);
    exp_q.push_back(24'hfa00ff);
    run(10);
    pulse_fs();
    run(3);
    last = 24'hfa00ff;
    commit(24'hff00ff);
    goto_hue(359); commit(24'hff0005);
    enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (hue != 9'd359) break;
    end
    enable = 1'b0;
    chk("hue wrap 359->0", 32'(hue), 32'd0);
    commit(24'hff0000);
    sat = 8'd0;   val = 8'd128;
    goto_hue(45);  commit(24'h808080);
    goto_hue(100); commit(24'h808080);
    sat = 8'd255; val = 8'd0;
    goto_hue(200); commit(24'h000000);
    sat = 8'd255; val = 8'd255;
    goto_hue(201); commit(24'h00a6ff);
    run(1000);
    chk("hue held with enable low", 32'(hue), 32'd201);
    goto_hue(202);
    run(3);
    rst_n = 1'b0;
    #1;
    chk("async reset hue", 32'(hue), 32'd0);
    chk("async reset duty", 32'({duty_r, duty_g, duty_b}), 32'd0);
    chk("async reset duty_valid", 32'(duty_valid), 32'd0);
    run(3);
    rst_n = 1'b1;
    last = 24'h0;
    run(1);
    chk("hue after reset release", 32'(hue), 32'd0);
    commit(24'hff0000);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
